// File: rtl/serial_adder_nbit.sv
// Bit-serial adder/subtractor: one full-adder slice plus carry flip-flop, LSB first.
// A start/busy/done handshake yields an N-bit sum, carry-out and signed overflow after WIDTH cycles.
module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_bit_s;
  logic             w_bit_c;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_run     = (r_state == S_RUN);
  assign w_accept  = start && !w_run;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_bit_s   = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_bit_c   = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
  assign w_res_nxt = {w_bit_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_bit_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // r_carry here is the carry into the MSB slice
        r_sum  <= w_res_nxt;
        r_cout <= w_bit_c;
        r_ovf  <= r_carry ^ w_bit_c;
      end
    end
  end

  assign busy = w_run;
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/serial_adder_nbit.md
# serial_adder_nbit

Parametrised bit-serial adder/subtractor for the arithmetic building-block set. A single full-adder slice with a carry flip-flop processes one operand bit per clock, LSB first. It uses a start/busy/done handshake and produces an N-bit sum, carry-out and signed-overflow flag. It is the sequential, width-generic successor to the gate-level half adder and is intended for area-constrained datapaths where latency is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request; sampled on a rising edge while busy=0.
- a  input  WIDTH  operand A, unsigned or two's complement; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add mode; captured on accepted start, ignored when sub=1.
- sub  input  1  0 = a+b+cin, 1 = a−b (a + ~b + 1); captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: result outputs updated this cycle.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  carry out of MSB (in sub mode, 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Accept: start=1 at an edge in IDLE or DONE. Effects:
  - Load operand shift registers with a and (sub ? ~b : b).
  - Set carry FF to (sub ? 1 : cin) and clear the bit counter.
  - Go to RUN.
- RUN, each edge:
  - s = a0^b0^c, c' = majority(a0,b0,c).
  - Shift both operand registers right one bit.
  - Shift s into the MSB end of the internal result shift register.
  - Increment the counter.
  - On the edge that processes bit WIDTH−1, record the carry into the MSB (the pre-step c) for ovf.
- After WIDTH bits: copy the internal result to sum and the final carry to cout, set ovf, go to DONE.
- DONE lasts one cycle with done=1, then goes to IDLE, or to RUN if start=1 on that edge.
- start while busy=1 is ignored; there is no queueing. a/b/cin/sub changes during RUN have no effect.
- sum/cout/ovf change only on transition into DONE. They hold the previous result throughout RUN.
- Counter width: $clog2(WIDTH+1) bits. Arithmetic is modulo 2^WIDTH. No sign extension.

## Timing
- Reset values:
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry FF and counter are 0. State=IDLE.
- Latency: start accepted at edge k → busy=1 from k to k+WIDTH → done=1 and results valid from edge k+WIDTH to k+WIDTH+1.
- Throughput: back-to-back start held during DONE gives one result every WIDTH+1 cycles.
- done is never asserted for more than one consecutive cycle per operation.
- rst asserted mid-RUN aborts the operation: all outputs go to reset values immediately (asynchronously), no done is produced, and IDLE is entered. The first edge after rst deasserts may accept start.
- start coincident with rst release edge: reset dominates while rst=1. start is sampled only at edges where rst=0.

## Test plan
- WIDTH=8, add: a=0x5A, b=0x3C, cin=0 → 8 cycles later sum=0x96, cout=0, ovf=1. done high exactly 1 cycle; busy high 8 cycles.
- WIDTH=8, add wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0, ovf=0.
- WIDTH=8, sub:
  - a=0x10, b=0x20 → sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
  - cin=1 is ignored in sub mode.
- Handshake:
  - Pulse start again and change a/b mid-RUN → no effect, and the result matches the original operands.
  - Hold start through DONE → next op accepted with no IDLE cycle, done spacing = 9 cycles.
- Reset mid-op: rst=1 at bit 4 of a run → busy/done/sum/cout/ovf=0 immediately with no clock edge. A following op completes correctly.
- WIDTH=4: exhaustive sweep of all a, b, cin, sub (1024 ops) against a reference model for sum, cout and ovf.
